// File: rtl/fetch_stage_pkg.sv
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared LC-3b types, fetch FSM state encoding and constants
//                for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    // Fetch controller states
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    // BR with nzp=000 never branches, so an all-zero word is a bubble
    localparam lc3b_word LC3B_NOP      = 16'h0000;
    localparam lc3b_word LC3B_RESET_PC = 16'h0000;

    // Instructions are word aligned: bit 0 of any fetch address is forced low
    function automatic lc3b_word align_pc(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_ifid_register.sv
// ============================================================================
//  Module      : fetch_stage_ifid_register
//  Description : IF/ID pipeline register. Flush beats stall, stall beats
//                load; with neither stall nor load it takes a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage_ifid_register
    import fetch_stage_pkg::*;
#(
    parameter lc3b_word NOP_INSTR = LC3B_NOP
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    input  logic     flush_i,
    input  logic     stall_i,
    input  logic     load_i,
    input  lc3b_word instr_i,
    input  lc3b_word pc_plus2_i,
    output logic     valid_o,
    output lc3b_word instr_o,
    output lc3b_word pc_plus2_o
);

    logic     valid_q,    valid_d;
    lc3b_word instr_q,    instr_d;
    lc3b_word pc_plus2_q, pc_plus2_d;

    // Next-state selection: flush > stall > load > bubble
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (stall_i) begin
            // decode is frozen on the current instruction
        end else if (load_i) begin
            valid_d    = 1'b1;
            instr_d    = instr_i;
            pc_plus2_d = pc_plus2_i;
        end else begin
            // nothing fetched this cycle: hand decode a bubble
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    // IF/ID storage with asynchronous reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : LC-3b instruction fetch. Owns the PC and the imem read
//                handshake, discards in-flight reads after a mispredict and
//                parks a fetched word while decode is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter lc3b_word RESET_PC  = LC3B_RESET_PC,
    parameter lc3b_word NOP_INSTR = LC3B_NOP
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    input  lc3b_word next_pc_i,
    input  logic     flush_i,
    input  logic     stall_in_i,
    input  logic     imem_resp_i,
    input  lc3b_word imem_rdata_i,
    output logic     imem_read_o,
    output lc3b_word imem_address_o,
    output logic     imem_stall_o,
    output lc3b_word pc_plus2_o,
    output lc3b_word fetch_instr_o,
    output logic     fetch_valid_o,
    output logic     id_valid_o,
    output lc3b_word id_instr_o,
    output lc3b_word id_pc_plus2_o
);

    fetch_state_t state_q;
    lc3b_word     pc_q;
    lc3b_word     hold_buf_q;
    lc3b_word     flush_tgt_q;

    lc3b_word     pc_plus2_d;
    lc3b_word     next_pc_d;
    logic         ifid_load_d;
    lc3b_word     ifid_instr_d;

    assign pc_plus2_d = pc_q + 16'd2;
    assign next_pc_d  = align_pc(next_pc_i);

    // Fetch FSM with PC, parked word and pending flush target
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            hold_buf_q  <= 16'h0000;
            flush_tgt_q <= 16'h0000;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_resp_i) begin
                        if (flush_i || !stall_in_i) begin
                            pc_q <= next_pc_d;
                        end else begin
                            hold_buf_q <= imem_rdata_i;
                            state_q    <= HOLD;
                        end
                    end else if (flush_i) begin
                        // the read in flight must still complete; remember where to go
                        flush_tgt_q <= next_pc_d;
                        state_q     <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_resp_i) begin
                        pc_q    <= flush_i ? next_pc_d : flush_tgt_q;
                        state_q <= FETCH;
                    end else if (flush_i) begin
                        flush_tgt_q <= next_pc_d;
                    end
                end
                HOLD: begin
                    if (flush_i || !stall_in_i) begin
                        pc_q    <= next_pc_d;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // IF/ID load request: a live word exists and neither flush nor stall blocks it
    always_comb begin
        ifid_load_d  = 1'b0;
        ifid_instr_d = imem_rdata_i;
        if (state_q == HOLD) begin
            ifid_instr_d = hold_buf_q;
            ifid_load_d  = !flush_i && !stall_in_i;
        end else if (state_q == FETCH) begin
            ifid_load_d  = imem_resp_i && !flush_i && !stall_in_i;
        end
    end

    fetch_stage_ifid_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .flush_i    (flush_i),
        .stall_i    (stall_in_i),
        .load_i     (ifid_load_d),
        .instr_i    (ifid_instr_d),
        .pc_plus2_i (pc_plus2_d),
        .valid_o    (id_valid_o),
        .instr_o    (id_instr_o),
        .pc_plus2_o (id_pc_plus2_o)
    );

    // Request is decoded from state but gated by reset so it drops immediately
    assign imem_read_o    = reset_n_i && (state_q != HOLD);
    assign imem_address_o = pc_q;
    assign imem_stall_o   = ((state_q == FETCH) && !imem_resp_i) || (state_q == DISCARD);
    assign pc_plus2_o     = pc_plus2_d;
    assign fetch_valid_o  = ((state_q == FETCH) && imem_resp_i) || (state_q == HOLD);
    assign fetch_instr_o  = (state_q == HOLD) ? hold_buf_q : imem_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed vector bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic [15:0] next_pc;
    logic        flush;
    logic        stall_in;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_stall;
    logic [15:0] pc_plus2;
    logic [15:0] fetch_instr;
    logic        fetch_valid;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .next_pc_i      (next_pc),
        .flush_i        (flush),
        .stall_in_i     (stall_in),
        .imem_resp_i    (imem_resp),
        .imem_rdata_i   (imem_rdata),
        .imem_read_o    (imem_read),
        .imem_address_o (imem_address),
        .imem_stall_o   (imem_stall),
        .pc_plus2_o     (pc_plus2),
        .fetch_instr_o  (fetch_instr),
        .fetch_valid_o  (fetch_valid),
        .id_valid_o     (id_valid),
        .id_instr_o     (id_instr),
        .id_pc_plus2_o  (id_pc_plus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl, st, rsp;
        logic [15:0] rdata, npc;
        logic        rd;
        logic [15:0] addr;
        logic        istall, fv;
        logic [15:0] fi;
        logic        idv;
        logic [15:0] idi, idp;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic fl, st, rsp, input logic [15:0] rdata, npc,
                                input logic rd, input logic [15:0] addr,
                                input logic istall, fv, input logic [15:0] fi,
                                input logic idv, input logic [15:0] idi, idp);
        vec_t v;
        v.fl = fl; v.st = st; v.rsp = rsp; v.rdata = rdata; v.npc = npc;
        v.rd = rd; v.addr = addr; v.istall = istall; v.fv = fv; v.fi = fi;
        v.idv = idv; v.idi = idi; v.idp = idp;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h, want %h", idx, name, act, exp);
        end
    endtask

    initial begin
        //           fl st rsp rdata     npc       rd addr     ist fv fi        idv idi       idp
        // 1-cycle imem, sequential fetch
        vecs[0]  = mk(0, 0, 1, 16'hA001, 16'h0002, 1, 16'h0000, 0, 1, 16'hA001, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 0, 1, 16'hA002, 16'h0004, 1, 16'h0002, 0, 1, 16'hA002, 1, 16'hA001, 16'h0002);
        vecs[2]  = mk(0, 0, 1, 16'hA003, 16'h0006, 1, 16'h0004, 0, 1, 16'hA003, 1, 16'hA002, 16'h0004);
        // response delayed three cycles
        vecs[3]  = mk(0, 0, 0, 16'h0000, 16'h0008, 1, 16'h0006, 1, 0, 16'h0000, 1, 16'hA003, 16'h0006);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 16'h0008, 1, 16'h0006, 1, 0, 16'h0000, 0, 16'h0000, 16'h0006);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 16'h0008, 1, 16'h0006, 1, 0, 16'h0000, 0, 16'h0000, 16'h0006);
        vecs[6]  = mk(0, 0, 1, 16'hB006, 16'h0008, 1, 16'h0006, 0, 1, 16'hB006, 0, 16'h0000, 16'h0006);
        // flush while waiting; stale word dropped, fetch resumes at 0040
        vecs[7]  = mk(1, 0, 0, 16'h0000, 16'h0040, 1, 16'h0008, 1, 0, 16'h0000, 1, 16'hB006, 16'h0008);
        vecs[8]  = mk(0, 0, 0, 16'h0000, 16'h000A, 1, 16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 16'h0008);
        vecs[9]  = mk(0, 0, 1, 16'hDEAD, 16'h000A, 1, 16'h0008, 1, 0, 16'h0000, 0, 16'h0000, 16'h0008);
        vecs[10] = mk(0, 0, 1, 16'hC040, 16'h0042, 1, 16'h0040, 0, 1, 16'hC040, 0, 16'h0000, 16'h0008);
        // stall at response -> HOLD, then release
        vecs[11] = mk(0, 1, 1, 16'h1234, 16'h0044, 1, 16'h0042, 0, 1, 16'h1234, 1, 16'hC040, 16'h0042);
        vecs[12] = mk(0, 1, 0, 16'h0000, 16'h0044, 0, 16'h0042, 0, 1, 16'h1234, 1, 16'hC040, 16'h0042);
        vecs[13] = mk(0, 0, 0, 16'h0000, 16'h0044, 0, 16'h0042, 0, 1, 16'h1234, 1, 16'hC040, 16'h0042);
        vecs[14] = mk(0, 0, 1, 16'h2222, 16'h0046, 1, 16'h0044, 0, 1, 16'h2222, 1, 16'h1234, 16'h0044);
        // flush under stall in HOLD, redirect to FFFE (pc_plus2 wraps)
        vecs[15] = mk(0, 1, 1, 16'h3333, 16'h0048, 1, 16'h0046, 0, 1, 16'h3333, 1, 16'h2222, 16'h0046);
        vecs[16] = mk(1, 1, 0, 16'h0000, 16'hFFFE, 0, 16'h0046, 0, 1, 16'h3333, 1, 16'h2222, 16'h0046);
        vecs[17] = mk(0, 0, 1, 16'h4444, 16'h0000, 1, 16'hFFFE, 0, 1, 16'h4444, 0, 16'h0000, 16'h0046);
        vecs[18] = mk(0, 0, 1, 16'h5555, 16'h0002, 1, 16'h0000, 0, 1, 16'h5555, 1, 16'h4444, 16'h0000);
        // flush with response in FETCH, repeated flush in DISCARD (newest wins)
        vecs[19] = mk(1, 0, 1, 16'h6666, 16'h0080, 1, 16'h0002, 0, 1, 16'h6666, 1, 16'h5555, 16'h0002);
        vecs[20] = mk(1, 0, 0, 16'h0000, 16'h0100, 1, 16'h0080, 1, 0, 16'h0000, 0, 16'h0000, 16'h0002);
        vecs[21] = mk(1, 0, 0, 16'h0000, 16'h0200, 1, 16'h0080, 1, 0, 16'h0000, 0, 16'h0000, 16'h0002);
        vecs[22] = mk(0, 0, 1, 16'h7777, 16'h0300, 1, 16'h0080, 1, 0, 16'h0000, 0, 16'h0000, 16'h0002);
        vecs[23] = mk(0, 0, 0, 16'h0000, 16'h0202, 1, 16'h0200, 1, 0, 16'h0000, 0, 16'h0000, 16'h0002);
        // flush and response together in DISCARD; odd target has bit 0 cleared
        vecs[24] = mk(1, 0, 0, 16'h0000, 16'h0400, 1, 16'h0200, 1, 0, 16'h0000, 0, 16'h0000, 16'h0002);
        vecs[25] = mk(1, 0, 1, 16'h8888, 16'h0501, 1, 16'h0200, 1, 0, 16'h0000, 0, 16'h0000, 16'h0002);
        vecs[26] = mk(0, 0, 1, 16'h9999, 16'h0502, 1, 16'h0500, 0, 1, 16'h9999, 0, 16'h0000, 16'h0002);
        // stall with no response holds IF/ID
        vecs[27] = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 16'h0502, 1, 0, 16'h0000, 1, 16'h9999, 16'h0502);
        vecs[28] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0502, 1, 0, 16'h0000, 1, 16'h9999, 16'h0502);

        // reset state
        reset_n    = 1'b0;
        next_pc    = 16'h0000;
        flush      = 1'b0;
        stall_in   = 1'b0;
        imem_resp  = 1'b0;
        imem_rdata = 16'h0000;
        #3;
        chk(-1, "rst imem_read",    {15'd0, imem_read},   16'h0000);
        chk(-1, "rst imem_address", imem_address,         16'h0000);
        chk(-1, "rst id_valid",     {15'd0, id_valid},    16'h0000);
        chk(-1, "rst id_instr",     id_instr,             16'h0000);
        chk(-1, "rst id_pc_plus2",  id_pc_plus2,          16'h0000);
        chk(-1, "rst pc_plus2",     pc_plus2,             16'h0002);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            flush      = vecs[i].fl;
            stall_in   = vecs[i].st;
            imem_resp  = vecs[i].rsp;
            imem_rdata = vecs[i].rdata;
            next_pc    = vecs[i].npc;
            #1;
            chk(i, "imem_read",    {15'd0, imem_read},   {15'd0, vecs[i].rd});
            chk(i, "imem_address", imem_address,         vecs[i].addr);
            chk(i, "imem_stall",   {15'd0, imem_stall},  {15'd0, vecs[i].istall});
            chk(i, "fetch_valid",  {15'd0, fetch_valid}, {15'd0, vecs[i].fv});
            if (vecs[i].fv)
                chk(i, "fetch_instr", fetch_instr, vecs[i].fi);
            chk(i, "pc_plus2",     pc_plus2,             vecs[i].addr + 16'd2);
            chk(i, "id_valid",     {15'd0, id_valid},    {15'd0, vecs[i].idv});
            chk(i, "id_instr",     id_instr,             vecs[i].idi);
            chk(i, "id_pc_plus2",  id_pc_plus2,          vecs[i].idp);
        end

        // reset asserted in the middle of DISCARD
        @(negedge clk);
        flush     = 1'b1;
        imem_resp = 1'b0;
        next_pc   = 16'h0600;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk(100, "discard imem_stall", {15'd0, imem_stall}, 16'h0001);
        chk(100, "discard imem_read",  {15'd0, imem_read},  16'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        chk(101, "rst2 imem_read",    {15'd0, imem_read}, 16'h0000);
        chk(101, "rst2 imem_address", imem_address,       16'h0000);
        chk(101, "rst2 id_valid",     {15'd0, id_valid},  16'h0000);
        chk(101, "rst2 id_instr",     id_instr,           16'h0000);
        @(negedge clk);
        reset_n    = 1'b1;
        imem_resp  = 1'b1;
        imem_rdata = 16'hABCD;
        next_pc    = 16'h0002;
        #1;
        chk(102, "post imem_read",   {15'd0, imem_read},   16'h0001);
        chk(102, "post imem_stall",  {15'd0, imem_stall},  16'h0000);
        chk(102, "post fetch_valid", {15'd0, fetch_valid}, 16'h0001);
        chk(102, "post imem_address", imem_address,        16'h0000);
        @(negedge clk);
        imem_resp = 1'b0;
        #1;
        chk(103, "post id_valid",    {15'd0, id_valid},    16'h0001);
        chk(103, "post id_instr",    id_instr,             16'hABCD);
        chk(103, "post id_pc_plus2", id_pc_plus2,          16'h0002);
        chk(103, "post imem_address", imem_address,        16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
